// File: rtl/permutation_engine_pkg.sv
// permutation_engine_pkg: shared types, limits and round primitives for the Ascon permutation core
package permutation_engine_pkg;
    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] t_cnt;
    localparam t_cnt MAX_ROUNDS = 4'd12;
    // Element 0 is x0, element 4 is x4
    typedef logic [0:4][63:0] t_state_array;
    typedef enum logic [1:0] {IDLE, RUN, DONE} t_perm_fsm;

    function automatic logic [7:0] round_const(input t_cnt idx);
        return {4'hf - idx, idx};
    endfunction

    // Bit-sliced Ascon S-box on one column; x[4] carries x0
    function automatic logic [4:0] sbox5(input logic [4:0] x);
        logic x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = x[4] ^ x[0];
        x1 = x[3];
        x2 = x[2] ^ x[3];
        x3 = x[1];
        x4 = x[0] ^ x[1];
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        return {x0, x1, x2, x3, x4};
    endfunction
endpackage

// File: rtl/permutation_engine_if.sv
// permutation_engine_if: start/result handshake between the mode controller and the permutation core
interface permutation_engine_if;
    import permutation_engine_pkg::*;
    logic         start;
    t_cnt         rounds;
    t_state_array init_state;
    logic         ready;
    logic         valid;
    t_state_array state;

    modport master (output start, rounds, init_state, input ready, valid, state);
    modport slave (input start, rounds, init_state, output ready, valid, state);
endinterface

// File: rtl/diffusion_layer.sv
// diffusion_layer: Ascon linear layer, each word XORed with two rotations of itself
module diffusion_layer
    import permutation_engine_pkg::*;
(
    input  t_state_array din,
    output t_state_array dout
);
    function automatic logic [63:0] ror(input logic [63:0] x, input int k);
        return (x >> k) | (x << (64 - k));
    endfunction

    assign dout[0] = din[0] ^ ror(din[0], 19) ^ ror(din[0], 28);
    assign dout[1] = din[1] ^ ror(din[1], 61) ^ ror(din[1], 39);
    assign dout[2] = din[2] ^ ror(din[2], 1) ^ ror(din[2], 6);
    assign dout[3] = din[3] ^ ror(din[3], 10) ^ ror(din[3], 17);
    assign dout[4] = din[4] ^ ror(din[4], 7) ^ ror(din[4], 41);
endmodule

// File: rtl/substitution_layer.sv
// substitution_layer: applies the 5-bit Ascon S-box to all 64 bit-slices of the state
module substitution_layer
    import permutation_engine_pkg::*;
(
    input  t_state_array din,
    output t_state_array dout
);
    for (genvar i = 0; i < 64; i++) begin : g_slice
        assign {dout[0][i], dout[1][i], dout[2][i], dout[3][i], dout[4][i]} =
            sbox5({din[0][i], din[1][i], din[2][i], din[3][i], din[4][i]});
    end
endmodule

// File: rtl/permutation_engine.sv
// permutation_engine: iterative Ascon permutation, one full round per clock, round count set per call
module permutation_engine
    import permutation_engine_pkg::*;
(
    input logic clk,
    input logic rst,
    permutation_engine_if.slave bus
);
    t_perm_fsm    fsm;
    t_state_array st, cadd, sub, rnd;
    t_cnt         cnt, n, clamp;
    logic         valid, ready;

    assign clamp = (bus.rounds > MAX_ROUNDS) ? MAX_ROUNDS : bus.rounds;

    // Short calls use the tail of the 12-round constant schedule
    always_comb begin
        cadd = st;
        cadd[2][7:0] = st[2][7:0] ^ round_const(MAX_ROUNDS - n + cnt);
    end

    substitution_layer u_sub (.din(cadd), .dout(sub));
    diffusion_layer u_diff (.din(sub), .dout(rnd));

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm   <= IDLE;
            st    <= '0;
            cnt   <= '0;
            n     <= '0;
            valid <= 1'b0;
            ready <= 1'b1;
        end else if (ready && bus.start) begin
            st    <= bus.init_state;
            n     <= clamp;
            cnt   <= '0;
            fsm   <= (clamp != '0) ? RUN : DONE;
            valid <= (clamp == '0);
            ready <= (clamp == '0);
        end else if (fsm == RUN) begin
            st  <= rnd;
            cnt <= cnt + t_cnt'(1);
            if (cnt == n - t_cnt'(1)) begin
                fsm   <= DONE;
                valid <= 1'b1;
                ready <= 1'b1;
            end
        end else begin
            fsm   <= IDLE;
            valid <= 1'b0;
        end
    end

    assign bus.state = st;
    assign bus.valid = valid;
    assign bus.ready = ready;
endmodule

// File: tb/tb_permutation_engine.sv
// tb_permutation_engine: randomized self-checking bench against a table-driven Ascon reference model
module tb_permutation_engine;
    import permutation_engine_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    permutation_engine_if bus ();
    permutation_engine dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    function automatic logic [63:0] rot(input logic [63:0] x, input int k);
        logic [127:0] d;
        d = {x, x} >> k;
        return d[63:0];
    endfunction

    function automatic t_state_array model(input t_state_array s, input int r);
        t_state_array t;
        logic [4:0]   v;
        int           n, idx;
        t = s;
        n = (r > 12) ? 12 : r;
        for (int k = 0; k < n; k++) begin
            idx = 12 - n + k;
            t[2] = t[2] ^ 64'(((15 - idx) << 4) | idx);
            for (int b = 0; b < 64; b++) begin
                v = SBOX[{t[0][b], t[1][b], t[2][b], t[3][b], t[4][b]}];
                {t[0][b], t[1][b], t[2][b], t[3][b], t[4][b]} = v;
            end
            for (int w = 0; w < 5; w++) t[w] = t[w] ^ rot(t[w], ROT_A[w]) ^ rot(t[w], ROT_B[w]);
        end
        return t;
    endfunction

    function automatic t_state_array rand_state();
        t_state_array s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic call(input t_state_array s, input int r, output int lat, output t_state_array res);
        @(negedge clk);
        bus.start = 1'b1;
        bus.rounds = t_cnt'(r);
        bus.init_state = s;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 1;
        while (!bus.valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        res = bus.state;
    endtask

    task automatic check_no_repeat(input string name);
        @(posedge clk);
        #1 tests++;
        if (bus.valid !== 1'b0) begin
            fails++;
            $display("FAIL %s: valid=%b in cycle after pulse, required 0", name, bus.valid);
        end
    endtask

    task automatic test_reset();
        t_state_array zero;
        int           seen;
        zero = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 tests += 3;
        if (bus.ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", bus.ready); end
        if (bus.valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b required 0", bus.valid); end
        if (bus.state !== zero) begin fails++; $display("FAIL reset_state: got %h required 0", bus.state); end
        @(negedge clk) rst = 1'b0;
        bus.start = 1'b1;
        bus.rounds = 4'd12;
        bus.init_state = rand_state();
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 tests += 2;
        if (bus.ready !== 1'b1) begin fails++; $display("FAIL midrun_reset_ready: got %b required 1", bus.ready); end
        if (bus.state !== zero) begin fails++; $display("FAIL midrun_reset_state: got %h required 0", bus.state); end
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (bus.valid) seen++;
        end
        tests++;
        if (seen != 0) begin fails++; $display("FAIL midrun_reset_pulse: got %0d valid pulses required 0", seen); end
    endtask

    task automatic test_one_round();
        t_state_array s, res;
        int           lat;
        s = '0;
        call(s, 1, lat, res);
        tests += 4;
        if (lat != 2) begin fails++; $display("FAIL one_round_latency: got %0d required 2", lat); end
        if (res[0] !== 64'h000964B00000004B) begin fails++; $display("FAIL one_round_x0: got %h required 000964b00000004b", res[0]); end
        if (res[4] !== 64'h0) begin fails++; $display("FAIL one_round_x4: got %h required 0", res[4]); end
        if (res !== model(s, 1)) begin fails++; $display("FAIL one_round_state: got %h required %h", res, model(s, 1)); end
        check_no_repeat("one_round_single_pulse");
    endtask

    task automatic test_p12_zero();
        t_state_array s, res;
        int           lat;
        s = '0;
        call(s, 12, lat, res);
        tests += 2;
        if (lat != 13) begin fails++; $display("FAIL p12_latency: got %0d required 13", lat); end
        if (res !== model(s, 12)) begin fails++; $display("FAIL p12_state: got %h required %h", res, model(s, 12)); end
        check_no_repeat("p12_single_pulse");
    endtask

    task automatic test_clamp_bounds();
        t_state_array s, res, res12;
        int           lat, lat12;
        s = rand_state();
        call(s, 0, lat, res);
        tests += 2;
        if (lat != 1) begin fails++; $display("FAIL zero_rounds_latency: got %0d required 1", lat); end
        if (res !== s) begin fails++; $display("FAIL zero_rounds_state: got %h required %h", res, s); end
        check_no_repeat("zero_rounds_single_pulse");
        s = rand_state();
        call(s, 15, lat, res);
        check_no_repeat("r15_single_pulse");
        call(s, 12, lat12, res12);
        check_no_repeat("r12_single_pulse");
        tests += 3;
        if (lat != 13) begin fails++; $display("FAIL r15_latency: got %0d required 13", lat); end
        if (res !== model(s, 12)) begin fails++; $display("FAIL r15_state: got %h required %h", res, model(s, 12)); end
        if (res !== res12 || lat != lat12) begin fails++; $display("FAIL r15_vs_r12: got %h/%0d required %h/%0d", res, lat, res12, lat12); end
    endtask

    task automatic test_start_in_run();
        t_state_array s1, s2;
        int           lat;
        s1 = rand_state();
        s2 = rand_state();
        @(negedge clk);
        bus.start = 1'b1;
        bus.rounds = 4'd12;
        bus.init_state = s1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 1;
        while (!bus.valid && lat < 40) begin
            if (lat == 3) begin
                bus.start = 1'b1;
                bus.rounds = 4'd1;
                bus.init_state = s2;
            end
            @(posedge clk);
            #1 bus.start = 1'b0;
            lat++;
        end
        tests += 2;
        if (lat != 13) begin fails++; $display("FAIL ignore_start_latency: got %0d required 13", lat); end
        if (bus.state !== model(s1, 12)) begin fails++; $display("FAIL ignore_start_state: got %h required %h", bus.state, model(s1, 12)); end
        check_no_repeat("ignore_start_single_pulse");
    endtask

    task automatic test_back_to_back();
        t_state_array s1, s2;
        int           lat;
        s1 = rand_state();
        s2 = rand_state();
        @(negedge clk);
        bus.start = 1'b1;
        bus.rounds = 4'd12;
        bus.init_state = s1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 1;
        while (!bus.valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        bus.start = 1'b1;
        bus.rounds = 4'd6;
        bus.init_state = s2;
        tests += 2;
        if (lat != 13) begin fails++; $display("FAIL b2b_first_latency: got %0d required 13", lat); end
        if (bus.state !== model(s1, 12)) begin fails++; $display("FAIL b2b_first_state: got %h required %h", bus.state, model(s1, 12)); end
        @(posedge clk);
        #1 bus.start = 1'b0;
        tests += 2;
        if (bus.ready !== 1'b0) begin fails++; $display("FAIL b2b_reload_ready: got %b required 0", bus.ready); end
        if (bus.valid !== 1'b0) begin fails++; $display("FAIL b2b_reload_valid: got %b required 0", bus.valid); end
        lat = 1;
        while (!bus.valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        tests += 2;
        if (lat != 7) begin fails++; $display("FAIL b2b_second_latency: got %0d required 7", lat); end
        if (bus.state !== model(s2, 6)) begin fails++; $display("FAIL b2b_second_state: got %h required %h", bus.state, model(s2, 6)); end
        check_no_repeat("b2b_single_pulse");
    endtask

    task automatic test_random();
        t_state_array s, res, exp;
        int           lat, r;
        for (int i = 0; i < 1000; i++) begin
            s = rand_state();
            case ($urandom_range(0, 2))
                0: r = 6;
                1: r = 8;
                default: r = 12;
            endcase
            call(s, r, lat, res);
            exp = model(s, r);
            tests += 2;
            if (lat != r + 1) begin fails++; $display("FAIL random_latency[%0d]: got %0d required %0d", i, lat, r + 1); end
            if (res !== exp) begin fails++; $display("FAIL random_state[%0d]: got %h required %h", i, res, exp); end
            check_no_repeat("random_single_pulse");
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.rounds = '0;
        bus.init_state = '0;
        test_reset();
        test_one_round();
        test_p12_zero();
        test_clamp_bounds();
        test_start_in_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/permutation_engine.md
Name: permutation_engine

Overview:
- Iterative Ascon permutation core that executes one full round per clock: constant addition, then substitution layer, then diffusion layer.
- The round result is fed back into the state register, and the iteration count is set per call (p^12 / p^8 / p^6).
- Sits between the mode controller (init/absorb/squeeze/finalise FSM) and the existing diffusion stage, which it instantiates as the last step of each round.

Parameters:
- MAX_ROUNDS, 12, maximum round count; also the base of the round-constant index.
- CNT_W, 4, width of the round counter and of i_rounds.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_start  input  1  start request, sampled only when o_ready=1.
- i_rounds  input  CNT_W  number of rounds to run, sampled with i_start.
- i_state  input  t_state_array (5x64)  initial state, sampled with i_start.
- o_ready  output  1  engine can accept i_start.
- o_valid  output  1  one-cycle pulse: o_state holds the final result.
- o_state  output  t_state_array  current state register (final result once o_valid has pulsed).

Behaviour:
- FSM states: IDLE, RUN, DONE. Register set: state_q (5x64), round counter cnt_q, target n_q.
- Reset (synchronous, i_rst=1 at a rising edge):
  - FSM goes to IDLE; state_q, cnt_q and n_q clear to 0.
  - Outputs: o_valid=0, o_ready=1, o_state=all-zero.
  - Reset wins over everything; a permutation in flight is abandoned and no o_valid is produced.
- o_ready = 1 in IDLE and DONE, 0 in RUN.
- Start (o_ready & i_start at a rising edge):
  - Loads state_q<=i_state and n_q<=min(i_rounds, MAX_ROUNDS); cnt_q<=0.
  - Next FSM state is RUN if n>0, else DONE.
  - In RUN, i_start is ignored and i_state/i_rounds are don't-care.
- Round r (cnt_q=r, 0..n-1), computed in one combinational path:
  - idx = MAX_ROUNDS - n_q + r; c = ((15-idx)<<4) | idx, an 8-bit value.
  - x2 ^= c in bits [7:0].
  - Apply the 5-bit Ascon S-box to each of the 64 bit-slices (x0 = MSB of the sbox input).
  - Apply the diffusion layer. state_q <= result; cnt_q <= cnt_q+1.
- RUN -> DONE on the edge that applies round n-1 (cnt_q==n_q-1).
- DONE:
  - o_valid=1 for exactly that one cycle.
  - Next state is IDLE, unless i_start is sampled in that cycle; then it reloads as above (back-to-back calls, no bubble).
- Latency: start sampled at edge E0 -> o_valid high during the cycle after edge E0+n.
  - p^12 gives 13 cycles from start to valid; n=0 gives 1 cycle, with o_state = i_state.
- Width rules:
  - i_rounds > MAX_ROUNDS clamps to MAX_ROUNDS; idx never exceeds 11.
  - cnt_q never wraps because it stops at n_q.
- o_state holds its value in IDLE/DONE until the next start; the mode controller reads it any time after o_valid.

Decomposition:
- ascon_pkg additions:
  - Localparam MAX_ROUNDS=12.
  - The round-constant function or table.
  - A typedef for the FSM state enum (t_perm_fsm).
- Reuse the existing t_state_array.
- Sub-modules:
  - New substitution_layer (t_state_array in/out, purely combinational, 64 bit-slice S-box instances); the natural extraction.
  - Existing diffusion_layer, instantiated as is.
- Constant addition stays inline.

Test Plan:
- Reset then idle: i_rst=1 for 2 cycles -> o_ready=1, o_valid=0, o_state all-zero; i_rst mid-RUN -> back to IDLE, no o_valid pulse.
- i_state all-zero, i_rounds=1 -> o_valid 2 cycles after start; x0=0x000964B00000004B; x4=0x0.
- i_state all-zero, i_rounds=12 -> o_valid exactly 13 cycles after start; o_state matches the C reference p^12 vector.
- i_rounds=0 with a random i_state -> o_valid 1 cycle later, o_state==i_state; i_rounds=15 -> identical result and latency to i_rounds=12.
- i_start pulsed during RUN with a different i_state -> ignored, result unchanged.
- i_start held high in the DONE cycle with i_rounds=6 -> reload with no idle cycle; second o_valid 7 cycles later, result matches the model.
- Random i_state with i_rounds in {6, 8, 12}, 1000 calls -> all match the golden model, o_valid pulses exactly once per call.
